// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, ALU codes, states, fields.
package cpu_control_fsm_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpJump  = 4'h3;
  localparam logic [3:0] OpJz    = 4'h4;
  localparam logic [3:0] OpSetf  = 4'h5;
  localparam logic [3:0] OpExec  = 4'h6;
  localparam logic [3:0] OpHalt  = 4'h7;

  localparam logic [3:0] AluAdd = 4'h0;
  localparam logic [3:0] AluSub = 4'h1;
  localparam logic [3:0] AluMul = 4'h2;
  localparam logic [3:0] AluDiv = 4'h3;
  localparam logic [3:0] AluAnd = 4'h4;
  localparam logic [3:0] AluOr  = 4'h5;
  localparam logic [3:0] AluXor = 4'h6;
  localparam logic [3:0] AluEq  = 4'h7;

  localparam int unsigned OpcodeMsb  = 15;
  localparam int unsigned OpcodeLsb  = 12;
  localparam int unsigned AddrFieldW = 12;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalted,
    StFault
  } state_e;

  // Opcodes 8-F are reserved and trap to FAULT.
  function automatic logic op_is_legal(logic [3:0] op);
    return !op[3];
  endfunction

endpackage

// File: rtl/cpu_control_fsm_pc.sv
// Program counter: load, increment with wrap, and a registered one-cycle wrap pulse.
module cpu_control_fsm_pc #(
  parameter int unsigned       AddrW   = 14,
  parameter logic [AddrW-1:0]  ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_val_i,
  input  logic             inc_i,
  output logic [AddrW-1:0] pc_o,
  output logic             wrap_o
);

  logic [AddrW-1:0] pc_d, pc_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d   = pc_q + 1'b1;
      wrap_d = &pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= ResetPc;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc_o   = pc_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU; owns IR, AC, F and the PC.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int unsigned      AddrW   = 14,
  parameter int unsigned      DataW   = 16,
  parameter logic [AddrW-1:0] ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  output logic             mem_we_o,
  input  logic [DataW-1:0] mem_rdata_i,
  output logic [3:0]       alu_op_o,
  output logic [DataW-1:0] alu_a_o,
  output logic [DataW-1:0] alu_b_o,
  input  logic [DataW-1:0] alu_result_i,
  output logic [DataW-1:0] acc_o,
  output logic [AddrW-1:0] pc_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic             pc_wrap_o
);

  state_e           state_q;
  logic [DataW-1:0] ir_q;
  logic [DataW-1:0] ac_q;
  logic [3:0]       f_q;

  logic [3:0]       op;
  logic [AddrW-1:0] ir_addr;
  logic [AddrW-1:0] pc;
  logic             pc_load;
  logic [AddrW-1:0] pc_load_val;
  logic             pc_inc;

  assign op      = ir_q[OpcodeMsb:OpcodeLsb];
  assign ir_addr = AddrW'(ir_q[AddrFieldW-1:0]);

  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = ResetPc;
    pc_inc      = 1'b0;
    case (state_q)
      StIdle, StHalted, StFault: pc_load = start_i;
      StDecode:                  pc_inc  = 1'b1;
      StExecute: begin
        pc_load_val = ir_addr;
        pc_load     = (op == OpJump) || ((op == OpJz) && (ac_q == '0));
      end
      default: ;
    endcase
  end

  cpu_control_fsm_pc #(
    .AddrW  (AddrW),
    .ResetPc(ResetPc)
  ) u_pc (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (pc_load),
    .load_val_i(pc_load_val),
    .inc_i     (pc_inc),
    .pc_o      (pc),
    .wrap_o    (pc_wrap_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ir_q    <= '0;
      ac_q    <= '0;
      f_q     <= AluAdd;
    end else begin
      case (state_q)
        StIdle, StHalted, StFault: if (start_i) state_q <= StFetch;
        StFetch: state_q <= StDecode;
        StDecode: begin
          ir_q    <= mem_rdata_i;
          state_q <= StExecute;
        end
        StExecute: begin
          case (op)
            OpLoad, OpExec: state_q <= StWriteback;
            OpHalt:         state_q <= StHalted;
            OpSetf: begin
              f_q     <= ir_q[3:0];
              state_q <= StFetch;
            end
            default: state_q <= op_is_legal(op) ? StFetch : StFault;
          endcase
        end
        StWriteback: begin
          // Operand word read in EXECUTE arrives on mem_rdata_i in this cycle.
          if ((op == OpExec) && (f_q == AluDiv) && (mem_rdata_i == '0)) begin
            state_q <= StFault;
          end else begin
            ac_q    <= (op == OpLoad) ? mem_rdata_i : alu_result_i;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decoded straight from state so a reset drops the write strobe without waiting for a clock.
  assign mem_we_o    = (state_q == StExecute) && (op == OpStore);
  assign mem_addr_o  = (state_q == StExecute) ? ir_addr : pc;
  assign mem_wdata_o = ac_q;
  assign alu_op_o    = f_q;
  assign alu_a_o     = ac_q;
  assign alu_b_o     = mem_rdata_i;
  assign acc_o       = ac_q;
  assign pc_o        = pc;
  assign busy_o      = (state_q == StFetch) || (state_q == StDecode) ||
                       (state_q == StExecute) || (state_q == StWriteback);
  assign halted_o    = (state_q == StHalted);
  assign fault_o     = (state_q == StFault);

endmodule
